// File: rtl/adder_pkg.sv
// Shared constants for the adder datapath and its operand debouncer.
package adder_pkg;

  localparam int unsigned OPERAND_W               = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: two-flop synchronizer, stability counter, output flop, update flag.
// The update flag is only built when DEBOUNCE_CHANGE_PULSE_EN is defined.
module debounce_channel
  import adder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic upd_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized level disagrees with the output.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

`ifdef DEBOUNCE_CHANGE_PULSE_EN
  logic upd_q, upd_d;

  always_comb begin
    upd_d = (s2_q != db_q) && (cnt_q == CntMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
    end
  end

  assign upd_o = upd_q;
`else
  assign upd_o = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Debounces the operand switches feeding tt_um_adder and flags updated bits.
// changed/chg_mask are live only with DEBOUNCE_CHANGE_PULSE_EN defined, else constant 0.
module input_debouncer
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH         = OPERAND_W,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic             changed,
  output logic [WIDTH-1:0] chg_mask
);

  logic [WIDTH-1:0] upd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw_in[i]),
      .db_o  (db_out[i]),
      .upd_o (upd[i])
    );
  end

  assign chg_mask = upd;
  assign changed  = |upd;

endmodule
